ast_video_packetizer: RTL and testbench

//  Parametrised successor to the BT.656 capture output stage. Accepts a cropped

---
 rtl/ast_video_packetizer.sv | 207 ++++++++++++++++++++
 tb/tb_ast_video_packetizer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_video_packetizer.sv
// ast_video_packetizer
// Turns a cropped pixel stream into Avalon-ST video. Each field or frame
// becomes one control packet followed by one video packet of exactly
// FRAME_WIDTH x FIELD_HEIGHT pixels. A sof that arrives early is repaired by
// padding. Surplus pixels after a complete packet are dropped.
// Optional feature macro: VID_PKT_STATS_EN enables frame_cnt, err_short and
// err_long. When the macro is undefined, those outputs are tied to 0.
module ast_video_packetizer #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int INTERLACED   = 1,
  parameter int PAD_VALUE    = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_sof,
  input  logic                  din_field,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  err_short,
  output logic                  err_long,
  output logic [15:0]           frame_cnt
);

  localparam int FIELD_HEIGHT = (INTERLACED != 0) ? FRAME_HEIGHT / 2 : FRAME_HEIGHT;
  localparam logic [15:0] WIDTH16   = 16'(FRAME_WIDTH);
  localparam logic [15:0] HEIGHT16  = 16'(FIELD_HEIGHT);
  localparam logic [15:0] PX_LAST   = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] LINE_LAST = 16'(FIELD_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] PAD_SYM = DATA_WIDTH'(PAD_VALUE);

  typedef enum logic [2:0] {IDLE, CTRL, HDR, VIDEO, PAD} state_t;

  state_t                state;
  logic [3:0]            ctrl_idx;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_field;
  logic                  hold_pending;
  logic [15:0]           px_cnt;
  logic [15:0]           line_cnt;

  logic                  out_free;
  logic                  sof_seen;
  logic                  frame_last;
  logic                  short_evt;
  logic                  pix_emit;
  logic                  pkt_done;
  logic [3:0]            il_nib;
  logic [3:0]            ctrl_nib;
  logic [DATA_WIDTH-1:0] ctrl_data;

  // Handshake decode, event strobes and control-packet nibble selection
  always_comb begin
    out_free   = !dout_valid || dout_ready;
    sof_seen   = din_valid && din_sof;
    frame_last = (px_cnt == PX_LAST) && (line_cnt == LINE_LAST);

    din_ready = 1'b0;
    case (state)
      IDLE:    din_ready = 1'b1;
      VIDEO:   din_ready = !hold_pending && out_free && !sof_seen;
      default: din_ready = 1'b0;
    endcase
    if (!reset_n) din_ready = 1'b0;

    short_evt = (state == VIDEO) && !hold_pending && sof_seen;
    pix_emit  = ((state == VIDEO) && out_free && hold_pending) ||
                ((state == VIDEO) && din_valid && din_ready) ||
                ((state == PAD) && out_free);
    pkt_done  = pix_emit && frame_last;

    il_nib = (INTERLACED != 0) ? {1'b1, hold_field, 2'b11} : 4'h0;
    case (ctrl_idx)
      4'd0:    ctrl_nib = 4'hF;
      4'd1:    ctrl_nib = WIDTH16[15:12];
      4'd2:    ctrl_nib = WIDTH16[11:8];
      4'd3:    ctrl_nib = WIDTH16[7:4];
      4'd4:    ctrl_nib = WIDTH16[3:0];
      4'd5:    ctrl_nib = HEIGHT16[15:12];
      4'd6:    ctrl_nib = HEIGHT16[11:8];
      4'd7:    ctrl_nib = HEIGHT16[7:4];
      4'd8:    ctrl_nib = HEIGHT16[3:0];
      4'd9:    ctrl_nib = il_nib;
      default: ctrl_nib = 4'h0;
    endcase
    ctrl_data      = '0;
    ctrl_data[3:0] = ctrl_nib;
  end

  // Packet sequencer with registered Avalon-ST outputs and pixel position counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      ctrl_idx           <= '0;
      hold_data          <= '0;
      hold_field         <= 1'b0;
      hold_pending       <= 1'b0;
      px_cnt             <= '0;
      line_cnt           <= '0;
      dout_data          <= '0;
      dout_valid         <= 1'b0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
    end else begin
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (sof_seen) begin
            hold_data  <= din_data;
            hold_field <= din_field;
            ctrl_idx   <= '0;
            state      <= CTRL;
          end
        end
        CTRL: begin
          if (out_free) begin
            dout_valid         <= 1'b1;
            dout_data          <= ctrl_data;
            dout_startofpacket <= (ctrl_idx == 4'd0);
            dout_endofpacket   <= (ctrl_idx == 4'd9);
            ctrl_idx           <= ctrl_idx + 4'd1;
            if (ctrl_idx == 4'd9) state <= HDR;
          end
        end
        HDR: begin
          if (out_free) begin
            dout_valid         <= 1'b1;
            dout_data          <= '0;
            dout_startofpacket <= 1'b1;
            dout_endofpacket   <= 1'b0;
            hold_pending       <= 1'b1;
            px_cnt             <= '0;
            line_cnt           <= '0;
            state              <= VIDEO;
          end
        end
        VIDEO: begin
          if (short_evt) begin
            state <= PAD;
          end else if (pix_emit) begin
            dout_valid         <= 1'b1;
            dout_data          <= hold_pending ? hold_data : din_data;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= frame_last;
            hold_pending       <= 1'b0;
            if (pkt_done) state <= IDLE;
          end
        end
        PAD: begin
          if (pix_emit) begin
            dout_valid         <= 1'b1;
            dout_data          <= PAD_SYM;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= frame_last;
            if (pkt_done) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (pix_emit && !short_evt) begin
        if (px_cnt == PX_LAST) begin
          px_cnt   <= '0;
          line_cnt <= (line_cnt == LINE_LAST) ? 16'd0 : line_cnt + 16'd1;
        end else begin
          px_cnt <= px_cnt + 16'd1;
        end
      end
    end
  end

`ifdef VID_PKT_STATS_EN
  logic drop_armed;
  logic drop_evt;

  assign drop_evt = (state == IDLE) && din_valid && !din_sof;

  // Statistics: completed packets, padding pulse, and the first drop after a completed packet
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      drop_armed <= 1'b0;
    end else begin
      err_short <= short_evt;
      err_long  <= drop_evt && drop_armed;
      if (pkt_done) frame_cnt <= frame_cnt + 16'd1;
      if (pkt_done) drop_armed <= 1'b1;
      else if (drop_evt || ((state == IDLE) && sof_seen)) drop_armed <= 1'b0;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_short = 1'b0;
  assign err_long  = 1'b0;
`endif

endmodule

// File: tb/tb_ast_video_packetizer.sv
// tb_ast_video_packetizer
// Directed bench. u_dut is an interlaced 8x4 instance and u_dut_p is a
// progressive 8x4 instance. Both use PAD_VALUE = 0xA5. Statistics expectations
// follow VID_PKT_STATS_EN.
module tb_ast_video_packetizer;

`ifdef VID_PKT_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic clock;
  logic reset_n;

  logic [7:0]  din_data, din_data_p;
  logic        din_valid, din_valid_p;
  logic        din_ready, din_ready_p;
  logic        din_sof, din_sof_p;
  logic        din_field, din_field_p;
  logic [7:0]  dout_data, dout_data_p;
  logic        dout_valid, dout_valid_p;
  logic        dout_ready, dout_ready_p;
  logic        dout_sop, dout_sop_p;
  logic        dout_eop, dout_eop_p;
  logic        err_short, err_short_p;
  logic        err_long, err_long_p;
  logic [15:0] frame_cnt, frame_cnt_p;

  int n_checks = 0;
  int n_fail   = 0;
  int es_cnt = 0, el_cnt = 0, es_p_cnt = 0, el_p_cnt = 0;
  bit bp_en = 0;
  bit stalled = 0;
  logic [10:0] stall_word;

  logic [9:0] got_q[$];
  logic [9:0] got_p_q[$];
  logic [9:0] exp_q[$];

  ast_video_packetizer #(.DATA_WIDTH(8), .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
                         .INTERLACED(1), .PAD_VALUE(165)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .din_sof(din_sof), .din_field(din_field),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop),
    .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt));

  ast_video_packetizer #(.DATA_WIDTH(8), .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
                         .INTERLACED(0), .PAD_VALUE(165)) u_dut_p (
    .clock(clock), .reset_n(reset_n),
    .din_data(din_data_p), .din_valid(din_valid_p), .din_ready(din_ready_p),
    .din_sof(din_sof_p), .din_field(din_field_p),
    .dout_data(dout_data_p), .dout_valid(dout_valid_p), .dout_ready(dout_ready_p),
    .dout_startofpacket(dout_sop_p), .dout_endofpacket(dout_eop_p),
    .err_short(err_short_p), .err_long(err_long_p), .frame_cnt(frame_cnt_p));

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison runs through here; failures are counted and reported.
  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Sink side: drive dout_ready on the falling edge, then sample just before
  // the rising edge. Capture transfers, check stall stability and count
  // error pulses.
  initial begin
    dout_ready   = 1'b1;
    dout_ready_p = 1'b1;
    forever begin
      @(negedge clock);
      dout_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (stalled)
        check_output("stall_hold", 32'({dout_valid, dout_sop, dout_eop, dout_data}), 32'(stall_word));
      stalled    = dout_valid && !dout_ready;
      stall_word = {dout_valid, dout_sop, dout_eop, dout_data};
      if (dout_valid && dout_ready) got_q.push_back({dout_sop, dout_eop, dout_data});
      if (dout_valid_p && dout_ready_p) got_p_q.push_back({dout_sop_p, dout_eop_p, dout_data_p});
      if (err_short === 1'b1) es_cnt++;
      if (err_long === 1'b1) el_cnt++;
      if (err_short_p === 1'b1) es_p_cnt++;
      if (err_long_p === 1'b1) el_p_cnt++;
    end
  end

  // Present one beat and hold it until the DUT accepts it. The number of
  // stall cycles is returned in waits.
  task automatic send_beat(input bit tgt, input logic [7:0] data, input logic sof,
                           input logic field, output int waits);
    bit   done;
    logic rdy;
    waits = 0;
    done  = 0;
    @(negedge clock);
    if (!tgt) begin
      din_data = data; din_valid = 1'b1; din_sof = sof; din_field = field;
    end else begin
      din_data_p = data; din_valid_p = 1'b1; din_sof_p = sof; din_field_p = field;
    end
    while (!done) begin
      #1;
      rdy = tgt ? din_ready_p : din_ready;
      @(posedge clock);
      if (rdy) begin
        done = 1;
      end else begin
        waits++;
        if (waits > 300) begin
          check_output("din_accept_timeout", 32'(rdy), 32'd1);
          done = 1;
        end else begin
          @(negedge clock);
        end
      end
    end
  endtask

  // Deassert both input streams, then idle for the requested number of cycles.
  task automatic din_idle(input int cycles);
    @(negedge clock);
    din_valid = 1'b0; din_sof = 1'b0;
    din_valid_p = 1'b0; din_sof_p = 1'b0;
    repeat (cycles) @(negedge clock);
  endtask

  // Send one field or frame of incrementing pixels, with sof on the first pixel.
  task automatic apply_stimulus(input bit tgt, input logic [7:0] base, input int npix, input logic field);
    int w;
    for (int i = 0; i < npix; i++) send_beat(tgt, 8'(base + 8'(i)), (i == 0), field, w);
  endtask

  // Expected control packet for an 8-pixel-wide picture.
  task automatic exp_ctrl(input logic [3:0] h_lsn, input logic [3:0] il);
    exp_q.push_back({2'b10, 8'h0F});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h08});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 4'h0, h_lsn});
    exp_q.push_back({2'b01, 4'h0, il});
  endtask

  task automatic exp_hdr();
    exp_q.push_back({2'b10, 8'h00});
  endtask

  task automatic exp_seq(input logic [7:0] base, input int n, input bit eop_last);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b0, eop_last && (i == n - 1), 8'(base + 8'(i))});
  endtask

  task automatic exp_pad(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), 8'hA5});
  endtask

  // Wait (bounded) for the expected number of beats. Then compare the count
  // and each beat, and clear the queues.
  task automatic compare_out(input bit tgt, input string tag);
    int c;
    int got_n;
    logic [9:0] g;
    c = 0;
    while (((tgt ? got_p_q.size() : got_q.size()) < exp_q.size()) && (c < 3000)) begin
      @(negedge clock);
      c++;
    end
    repeat (4) @(negedge clock);
    got_n = tgt ? got_p_q.size() : got_q.size();
    check_output({tag, "_count"}, 32'(got_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      if (tgt) g = got_p_q[i];
      else     g = got_q[i];
      check_output($sformatf("%s_beat%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
    got_p_q.delete();
  endtask

  // Directed test sequence.
  initial begin
    int w;
    din_data = '0; din_valid = 0; din_sof = 0; din_field = 0;
    din_data_p = '0; din_valid_p = 0; din_sof_p = 0; din_field_p = 0;
    reset_n = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    check_output("rst_dout_valid", 32'(dout_valid), 32'd0);
    check_output("rst_din_ready", 32'(din_ready), 32'd0);
    check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_output("rel_din_ready", 32'(din_ready), 32'd1);

    $display("[TB] reset in the middle of a control packet");
    send_beat(0, 8'h99, 1'b1, 1'b0, w);
    din_idle(3);
    check_output("t1_pre_valid", 32'(dout_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("t1_dout_valid", 32'(dout_valid), 32'd0);
    check_output("t1_dout_data", 32'(dout_data), 32'd0);
    check_output("t1_dout_sop", 32'(dout_sop), 32'd0);
    check_output("t1_dout_eop", 32'(dout_eop), 32'd0);
    check_output("t1_din_ready", 32'(din_ready), 32'd0);
    check_output("t1_err", 32'({err_short, err_long}), 32'd0);
    check_output("t1_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_output("t1_idle_din_ready", 32'(din_ready), 32'd1);
    repeat (3) @(negedge clock);
    #1;
    check_output("t1_idle_no_output", 32'(dout_valid), 32'd0);
    got_q.delete();
    got_p_q.delete();

    $display("[TB] nominal F0 field");
    apply_stimulus(0, 8'h01, 16, 1'b0);
    din_idle(1);
    exp_ctrl(4'h2, 4'hB); exp_hdr(); exp_seq(8'h01, 16, 1);
    compare_out(0, "t2");
    check_output("t2_frame_cnt", 32'(frame_cnt), 32'(STATS_ON));

    $display("[TB] backpressure, F0 then F1");
    bp_en = 1;
    apply_stimulus(0, 8'h20, 16, 1'b0);
    apply_stimulus(0, 8'h30, 16, 1'b1);
    din_idle(1);
    exp_ctrl(4'h2, 4'hB); exp_hdr(); exp_seq(8'h20, 16, 1);
    exp_ctrl(4'h2, 4'hF); exp_hdr(); exp_seq(8'h30, 16, 1);
    compare_out(0, "t3");
    bp_en = 0;
    check_output("t3_frame_cnt", 32'(frame_cnt), 32'(3 * STATS_ON));

    $display("[TB] short field padded");
    es_cnt = 0; el_cnt = 0;
    apply_stimulus(0, 8'h10, 5, 1'b0);
    apply_stimulus(0, 8'h40, 16, 1'b1);
    din_idle(1);
    exp_ctrl(4'h2, 4'hB); exp_hdr(); exp_seq(8'h10, 5, 0); exp_pad(11);
    exp_ctrl(4'h2, 4'hF); exp_hdr(); exp_seq(8'h40, 16, 1);
    compare_out(0, "t4");
    check_output("t4_err_short_pulses", 32'(es_cnt), 32'(STATS_ON));
    check_output("t4_err_long_pulses", 32'(el_cnt), 32'd0);
    check_output("t4_frame_cnt", 32'(frame_cnt), 32'(5 * STATS_ON));

    $display("[TB] long field trimmed");
    es_cnt = 0; el_cnt = 0;
    apply_stimulus(0, 8'h60, 16, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send_beat(0, 8'(8'h70 + 8'(k)), 1'b0, 1'b0, w);
      check_output($sformatf("t5_drop_wait%0d", k), 32'(w), 32'd0);
    end
    apply_stimulus(0, 8'h80, 16, 1'b1);
    din_idle(1);
    exp_ctrl(4'h2, 4'hB); exp_hdr(); exp_seq(8'h60, 16, 1);
    exp_ctrl(4'h2, 4'hF); exp_hdr(); exp_seq(8'h80, 16, 1);
    compare_out(0, "t5");
    check_output("t5_err_long_pulses", 32'(el_cnt), 32'(STATS_ON));
    check_output("t5_err_short_pulses", 32'(es_cnt), 32'd0);
    check_output("t5_frame_cnt", 32'(frame_cnt), 32'(7 * STATS_ON));

    $display("[TB] progressive instance, three frames");
    apply_stimulus(1, 8'hC0, 32, 1'b0);
    apply_stimulus(1, 8'h20, 32, 1'b0);
    apply_stimulus(1, 8'h50, 32, 1'b0);
    din_idle(1);
    exp_ctrl(4'h4, 4'h0); exp_hdr(); exp_seq(8'hC0, 32, 1);
    exp_ctrl(4'h4, 4'h0); exp_hdr(); exp_seq(8'h20, 32, 1);
    exp_ctrl(4'h4, 4'h0); exp_hdr(); exp_seq(8'h50, 32, 1);
    compare_out(1, "t6");
    check_output("t6_frame_cnt", 32'(frame_cnt_p), 32'(3 * STATS_ON));
    check_output("t6_err_short_pulses", 32'(es_p_cnt), 32'd0);
    check_output("t6_err_long_pulses", 32'(el_p_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
